// File: rtl/core_imem_responder.sv
// Instruction-memory responder for the core fetch port: loader-filled 64-bit SRAM,
// programmable wait states, external stall, one-cycle registered response.
module core_imem_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                           g_clk,
    input  logic                           g_resetn,
    input  logic                           imem_req,
    input  logic [63:0]                    imem_addr,
    output logic                           imem_gnt,
    output logic                           imem_err,
    output logic [63:0]                    imem_rdata,
    input  logic                           stall,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [63:0]                    ld_data,
    input  logic [7:0]                     ld_strb
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [64:0] END_EXT  = {1'b0, BASE_ADDR} + (65'(DEPTH_WORDS) << 3);
    localparam logic [63:0] END_ADDR = END_EXT[63:0];
    localparam logic [3:0]  WAIT_MAX = 4'(WAIT_CYCLES);

    logic [63:0]   mem [DEPTH_WORDS];
    logic [3:0]    wcnt_q, wcnt_d;
    logic          err_q, err_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          in_range_c;
    logic [AW-1:0] idx_c;

    // Address decode and grant are purely combinational on the request phase.
    always_comb begin
        in_range_c = (imem_addr >= BASE_ADDR) && (imem_addr < END_ADDR);
        idx_c      = AW'((imem_addr - BASE_ADDR) >> 3);
        imem_gnt   = imem_req && !stall && (wcnt_q == WAIT_MAX);
    end

    // Wait counter and response next-state; a read sees pre-write memory contents.
    always_comb begin
        wcnt_d  = wcnt_q;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        if (!imem_req || imem_gnt) begin
            wcnt_d = 4'd0;
        end else if (wcnt_q != WAIT_MAX) begin
            wcnt_d = wcnt_q + 4'd1;
        end
        if (imem_gnt) begin
            err_d   = !in_range_c;
            rdata_d = in_range_c ? mem[idx_c] : 64'h0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wcnt_q  <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 64'h0;
        end else begin
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Loader write port: byte-strobed, never back-pressured, contents not reset.
    always_ff @(posedge g_clk) begin
        if (ld_en) begin
            for (int b = 0; b < 8; b++) begin
                if (ld_strb[b]) begin
                    mem[ld_addr][8*b +: 8] <= ld_data[8*b +: 8];
                end
            end
        end
    end

    assign imem_err   = err_q;
    assign imem_rdata = rdata_q;

    // Configuration sanity: window must not wrap the address space.
    always_ff @(posedge g_clk) begin
        if (g_resetn) begin
            assert (!END_EXT[64] && (WAIT_CYCLES <= 15) && (DEPTH_WORDS >= 2)
                    && ((DEPTH_WORDS & (DEPTH_WORDS - 1)) == 0))
            else $error("core_imem_responder: invalid configuration");
        end
    end

endmodule

// File: tb/tb_core_imem_responder.sv
// Bench for core_imem_responder: two instances (0 and 3 wait states) checked every
// cycle against a behavioural model, plus directed scenarios with literal expectations.
module tb_core_imem_responder;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam logic [63:0] END_A = BASE + 64'(DEPTH * 8);

    int waits [2] = '{0, 3};

    logic          g_clk = 1'b0;
    logic          g_resetn = 1'b0;
    logic          req [2], stall [2], ld_en [2], gnt [2], err [2];
    logic [63:0]   addr [2], ld_data [2], rdata [2];
    logic [AW-1:0] ld_addr [2];
    logic [7:0]    ld_strb [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 g_clk = ~g_clk;

    core_imem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .g_clk(g_clk), .g_resetn(g_resetn), .imem_req(req[0]), .imem_addr(addr[0]),
        .imem_gnt(gnt[0]), .imem_err(err[0]), .imem_rdata(rdata[0]), .stall(stall[0]),
        .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .ld_strb(ld_strb[0]));

    core_imem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut1 (
        .g_clk(g_clk), .g_resetn(g_resetn), .imem_req(req[1]), .imem_addr(addr[1]),
        .imem_gnt(gnt[1]), .imem_err(err[1]), .imem_rdata(rdata[1]), .stall(stall[1]),
        .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .ld_strb(ld_strb[1]));

    // Behavioural model: memory image, cycles-held counter, expected response registers.
    logic [63:0] mmem [2][DEPTH];
    logic [63:0] img  [2][DEPTH];
    int          held [2] = '{0, 0};
    logic        exp_err [2];
    logic [63:0] exp_rdata [2];
    bit          last_gnt [2];
    bit          model_valid = 1'b0;

    function automatic bit inr(logic [63:0] a);
        return (a >= BASE) && (a < END_A);
    endfunction

    function automatic bit exp_gnt(int d);
        return req[d] && !stall[d] && (held[d] >= waits[d]);
    endfunction

    always @(posedge g_clk) begin
        for (int d = 0; d < 2; d++) begin
            bit g;
            logic [AW-1:0] w;
            g = exp_gnt(d);
            last_gnt[d] = g;
            w = AW'((addr[d] - BASE) >> 3);
            if (!g_resetn) begin
                exp_err[d]   = 1'b0;
                exp_rdata[d] = 64'h0;
            end else if (g) begin
                exp_err[d]   = !inr(addr[d]);
                exp_rdata[d] = inr(addr[d]) ? mmem[d][w] : 64'h0;
            end else begin
                exp_err[d] = 1'b0;
            end
            if (!g_resetn || g || !req[d]) held[d] = 0;
            else if (held[d] < 100) held[d] = held[d] + 1;
            if (ld_en[d]) begin
                for (int b = 0; b < 8; b++) begin
                    if (ld_strb[d][b]) mmem[d][ld_addr[d]][8*b +: 8] = ld_data[d][8*b +: 8];
                end
            end
        end
        if (!g_resetn) model_valid = 1'b1;
    end

    task automatic chk(string name, int d, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
        end
    endtask

    always @(negedge g_clk) begin
        if (model_valid) begin
            for (int d = 0; d < 2; d++) begin
                chk("model_gnt", d, 64'(gnt[d]), 64'(exp_gnt(d)));
                chk("model_err", d, 64'(err[d]), 64'(exp_err[d]));
                chk("model_rdata", d, rdata[d], exp_rdata[d]);
            end
        end
    end

    task automatic cyc();
        @(posedge g_clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge g_clk);
    endtask

    task automatic load_word(int d, int w, logic [63:0] data, logic [7:0] strb);
        ld_en[d] = 1'b1; ld_addr[d] = AW'(w); ld_data[d] = data; ld_strb[d] = strb;
        for (int b = 0; b < 8; b++) if (strb[b]) img[d][w][8*b +: 8] = data[8*b +: 8];
        cyc();
        ld_en[d] = 1'b0;
    endtask

    task automatic expect_wait3(logic [63:0] a);
        req[1] = 1'b1; addr[1] = a;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("wait3_gnt", 1, 64'(gnt[1]), 64'(i == 3));
            if (i < 3) cyc();
        end
        cyc();
        req[1] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = 0; stall[d] = 0; ld_en[d] = 0; addr[d] = BASE;
            ld_data[d] = 0; ld_addr[d] = 0; ld_strb[d] = 0;
        end
        cyc(); cyc();
        at_neg();
        for (int d = 0; d < 2; d++) begin
            chk("reset_err", d, 64'(err[d]), 64'h0);
            chk("reset_rdata", d, rdata[d], 64'h0);
        end
        cyc();
        g_resetn = 1'b1;

        for (int w = 0; w < int'(DEPTH); w++) begin
            for (int d = 0; d < 2; d++) begin
                ld_en[d] = 1'b1; ld_addr[d] = AW'(w); ld_strb[d] = 8'hFF;
                ld_data[d] = {$urandom, $urandom};
                img[d][w] = ld_data[d];
            end
            cyc();
        end
        ld_en[0] = 1'b0; ld_en[1] = 1'b0;

        // Single zero-wait read
        load_word(0, 0, 64'h0011223344556677, 8'hFF);
        req[0] = 1'b1; addr[0] = BASE;
        at_neg(); chk("t1_gnt", 0, 64'(gnt[0]), 64'h1);
        cyc(); req[0] = 1'b0;
        at_neg(); chk("t1_rdata", 0, rdata[0], 64'h0011223344556677);
        chk("t1_err", 0, 64'(err[0]), 64'h0);

        // Back-to-back reads
        cyc();
        req[0] = 1'b1; addr[0] = BASE;
        at_neg(); chk("b2b_gnt0", 0, 64'(gnt[0]), 64'h1);
        cyc(); addr[0] = BASE + 64'h8;
        at_neg(); chk("b2b_gnt1", 0, 64'(gnt[0]), 64'h1);
        chk("b2b_rd0", 0, rdata[0], 64'h0011223344556677);
        cyc(); addr[0] = BASE + 64'h10;
        at_neg(); chk("b2b_gnt2", 0, 64'(gnt[0]), 64'h1);
        chk("b2b_rd1", 0, rdata[0], img[0][1]);
        cyc(); req[0] = 1'b0;
        at_neg(); chk("b2b_rd2", 0, rdata[0], img[0][2]);
        chk("b2b_idle_gnt", 0, 64'(gnt[0]), 64'h0);

        // Three wait states, unaligned address
        cyc();
        expect_wait3(BASE + 64'h4);
        at_neg(); chk("w3_rdata", 1, rdata[1], img[1][0]);
        chk("w3_err", 1, 64'(err[1]), 64'h0);

        // Abandon after two cycles, then a full-length re-request
        cyc();
        req[1] = 1'b1; addr[1] = BASE + 64'h8;
        for (int i = 0; i < 2; i++) begin
            at_neg(); chk("abandon_gnt", 1, 64'(gnt[1]), 64'h0);
            cyc();
        end
        req[1] = 1'b0;
        at_neg(); chk("abandon_gnt_off", 1, 64'(gnt[1]), 64'h0);
        chk("abandon_err", 1, 64'(err[1]), 64'h0);
        cyc();
        expect_wait3(BASE + 64'h8);
        at_neg(); chk("rereq_rdata", 1, rdata[1], img[1][1]);

        // Out-of-range below and just past the window
        cyc();
        req[0] = 1'b1; addr[0] = 64'h7FFF_FFF8;
        at_neg(); chk("oor_lo_gnt", 0, 64'(gnt[0]), 64'h1);
        cyc(); addr[0] = END_A;
        at_neg(); chk("oor_hi_gnt", 0, 64'(gnt[0]), 64'h1);
        chk("oor_lo_err", 0, 64'(err[0]), 64'h1);
        chk("oor_lo_rdata", 0, rdata[0], 64'h0);
        cyc(); req[0] = 1'b0;
        at_neg(); chk("oor_hi_err", 0, 64'(err[0]), 64'h1);
        chk("oor_hi_rdata", 0, rdata[0], 64'h0);
        cyc();
        at_neg(); chk("oor_err_clear", 0, 64'(err[0]), 64'h0);

        // Read/write collision returns old data
        load_word(0, 5, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
        req[0] = 1'b1; addr[0] = BASE + 64'h28;
        ld_en[0] = 1'b1; ld_addr[0] = AW'(5); ld_strb[0] = 8'h0F; ld_data[0] = 64'h0;
        img[0][5] = 64'hAAAA_AAAA_0000_0000;
        at_neg(); chk("coll_gnt", 0, 64'(gnt[0]), 64'h1);
        cyc(); ld_en[0] = 1'b0;
        at_neg(); chk("coll_old", 0, rdata[0], 64'hAAAA_AAAA_AAAA_AAAA);
        cyc(); req[0] = 1'b0;
        at_neg(); chk("coll_new", 0, rdata[0], 64'hAAAA_AAAA_0000_0000);

        // Stall holds off grant; reset kills a pending response
        cyc();
        req[0] = 1'b1; stall[0] = 1'b1; addr[0] = BASE + 64'h8;
        for (int i = 0; i < 5; i++) begin
            at_neg(); chk("stall_gnt", 0, 64'(gnt[0]), 64'h0);
            cyc();
        end
        stall[0] = 1'b0;
        at_neg(); chk("unstall_gnt", 0, 64'(gnt[0]), 64'h1);
        cyc();
        addr[0] = 64'h7FFF_FFF8; g_resetn = 1'b0;
        at_neg(); chk("pre_rst_rdata", 0, rdata[0], img[0][1]);
        chk("pre_rst_gnt", 0, 64'(gnt[0]), 64'h1);
        cyc();
        at_neg(); chk("rst_err", 0, 64'(err[0]), 64'h0);
        chk("rst_rdata", 0, rdata[0], 64'h0);
        req[0] = 1'b0; g_resetn = 1'b1;

        // Randomized traffic on both instances
        for (int c = 0; c < 2000; c++) begin
            cyc();
            g_resetn = ($urandom % 100) != 0;
            for (int d = 0; d < 2; d++) begin
                if (req[d] && !last_gnt[d]) begin
                    if (($urandom % 10) == 0) req[d] = 1'b0;
                end else begin
                    int unsigned r;
                    r = $urandom % 10;
                    req[d] = ($urandom % 10) < 7;
                    if (r < 8)
                        addr[d] = BASE + 64'($urandom_range(DEPTH - 1, 0)) * 64'd8 + 64'($urandom % 8);
                    else if (r == 8)
                        addr[d] = BASE - 64'd8 * 64'(1 + $urandom % 4);
                    else
                        addr[d] = END_A + 64'($urandom % 16);
                end
                stall[d]   = ($urandom % 5) == 0;
                ld_en[d]   = ($urandom % 3) == 0;
                ld_addr[d] = AW'($urandom % DEPTH);
                ld_data[d] = {$urandom, $urandom};
                ld_strb[d] = 8'($urandom);
            end
        end
        for (int d = 0; d < 2; d++) begin
            req[d] = 0; stall[d] = 0; ld_en[d] = 0;
        end
        g_resetn = 1'b1;
        cyc(); cyc();
        at_neg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_imem_responder.md
Name: core_imem_responder

Overview:
- Instruction-memory responder for the core fetch interface (imem_req/imem_addr/imem_gnt/imem_err/imem_rdata).
- Backed by a 64-bit-wide synchronous SRAM array that a loader write port fills before or during execution.
- Adds a configurable wait-state counter and an external stall input, so fetch back-pressure and abandoned requests can be exercised.
- Used as the instruction memory in core-level simulation and in FPGA builds.

Parameters:
- BASE_ADDR, 64'h80000000: byte address of word 0; matches the core PC reset address.
- DEPTH_WORDS, 1024: number of 64-bit words; must be a power of 2, at least 2.
- WAIT_CYCLES, 0: minimum cycles req must be held before gnt; range 0..15.

Ports:
- g_clk  in  1  Global clock.
- g_resetn  in  1  Global reset; synchronous, active-low.
- imem_req  in  1  Fetch request.
- imem_addr  in  64  Request byte address; bits [2:0] are ignored.
- imem_gnt  out  1  Request accepted this cycle.
- imem_err  out  1  Response error; valid in the cycle after gnt.
- imem_rdata  out  64  Response doubleword; valid in the cycle after gnt.
- stall  in  1  When high, forces gnt low.
- ld_en  in  1  Loader write enable.
- ld_addr  in  log2(DEPTH_WORDS)  Loader word index.
- ld_data  in  64  Loader write data.
- ld_strb  in  8  Loader byte enables; bit i enables ld_data[8i+7:8i].

Behaviour:
- Reset values: imem_err = 0, imem_rdata = 0, wait counter = 0. imem_gnt is combinational and is 0 whenever req is low. SRAM contents are not reset.
- Word index: idx = (imem_addr - BASE_ADDR) >> 3, computed with 64-bit unsigned subtraction.
- in_range = imem_addr >= BASE_ADDR && imem_addr < BASE_ADDR + DEPTH_WORDS*8.
- Wait counter wcnt (4 bits):
  - cleared when req is low or when gnt is high;
  - otherwise increments, saturating at WAIT_CYCLES.
- Grant: imem_gnt = imem_req && !stall && (wcnt == WAIT_CYCLES).
  - With WAIT_CYCLES = 0 and stall low, gnt = req, giving one access per cycle with back-to-back requests.
- Request and address stability:
  - The requester keeps addr stable while req is high and ungranted. The responder samples addr only in the gnt cycle.
  - The requester may drop req before gnt (abandon). No response is produced and wcnt clears.
  - Re-asserting req restarts the wait count from 0.
- Response, one cycle after gnt:
  - in range: imem_rdata = mem[idx], imem_err = 0;
  - out of range: imem_rdata = 64'h0, imem_err = 1.
- Outside response cycles:
  - imem_rdata holds its last value;
  - imem_err = 0.
- Back-to-back grants produce back-to-back responses in order, one per cycle.
- Loader port:
  - When ld_en is high, strobed bytes of mem[ld_addr] are written at the clock edge.
  - The loader ignores stall and has no handshake; it is always accepted.
- Read/write collision: a gnt and an ld_en to the same word in the same cycle return the OLD data (read-before-write). The new data is visible to the next grant.
- stall rising while a request waits: wcnt keeps counting up to saturation. gnt occurs in the first cycle that stall is low.
- Reset asserted mid-operation:
  - any pending response is lost;
  - err and rdata return to 0 on the next edge;
  - wcnt clears.
- Address wrap: if BASE_ADDR + DEPTH_WORDS*8 overflows 64 bits, that is a configuration error. An assertion fires in simulation.

Test Plan:
- Reset only, WAIT_CYCLES=0:
  - loader writes mem[0]=64'h0011223344556677;
  - req=1, addr=64'h80000000 -> gnt=1 in the same cycle; next cycle rdata=64'h0011223344556677, err=0.
- Back-to-back, WAIT_CYCLES=0:
  - addrs 0x80000000, 0x80000008, 0x80000010 on consecutive cycles -> gnt high for 3 cycles;
  - responses are mem[0], mem[1], mem[2] on the next 3 cycles.
- WAIT_CYCLES=3:
  - req held at 0x80000004 -> gnt in the 4th cycle of req; rdata=mem[0] the following cycle (addr[2:0] ignored).
  - Dropping req after 2 cycles -> no gnt, err stays 0, and a re-request again needs 4 cycles.
- Error response: addr=64'h7FFFFFF8, then addr=0x80000000+DEPTH_WORDS*8 -> each granted; next cycle err=1, rdata=0. The cycle after that, err=0.
- Collision:
  - mem[5]=64'hAAAA...AA;
  - same cycle: gnt on addr 0x80000028 and ld_en with ld_addr=5, ld_strb=8'h0F, ld_data=64'h0 -> response is 64'hAAAA...AA;
  - next read of mem[5] -> 64'hAAAAAAAA00000000.
- Stall: stall=1 for 5 cycles with req high (WAIT_CYCLES=0) -> gnt=0 throughout. Stall falls -> gnt=1 in the same cycle. Reset asserted during a response cycle -> rdata=0, err=0 after the edge.
